rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two sources.
//  Port A is the pipeline writeback stage: highest priority, no backpressure.
//  Port B is multi-cycle units (mult/div, exception $k0/$ra writes): valid/ready handshake.
//  Accepted B writes wait in a small in-order queue and drain on cycles where A does not write.
//  A per-register pending mask lets the hazard unit stall readers of queued registers.
// PARAMETERS
//  DEPTH        2   B-queue entries (1..4)
//  STARVE_LIMIT 8   cycles a queue head may wait before a_stall is requested
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  a_we        in   1   pipeline writeback enable
//  a_addr      in   5   pipeline writeback register
//  a_data      in   32  pipeline writeback data
//  b_valid     in   1   multi-cycle result valid
//  b_ready     out  1   queue can accept B (count < DEPTH)
//  b_addr      in   5   B destination register
//  b_data      in   32  B data
//  rf_we       out  1   register-file write enable
//  rf_waddr    out  5   register-file write address
//  rf_wdata    out  32  register-file write data
//  pend_mask   out  32  bit r set while a live queue entry targets r
//  a_stall     out  1   request pipeline to suppress writeback next cycle
// BEHAVIOUR
//  Reset (reset==0, asynchronous): queue empty, count=0, starve counter=0.
//   b_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, a_stall=0.
//   Entries in flight are discarded.
//  Definitions: A_act = a_we && a_addr!=0. B_acc = b_valid && b_ready.
//  Write-port select is combinational, 0-cycle latency. Priority, first match wins:
//   1) A_act: rf_* = A.
//   2) Queue head live: rf_* = head; pop at the clock edge.
//   3) Queue empty and B_acc and b_addr!=0: rf_* = B directly; nothing is enqueued.
//   4) Otherwise rf_we=0. rf_waddr/rf_wdata hold 0.
//  Enqueue: on B_acc with b_addr!=0, enqueue at the tail, unless case 3 consumed B this cycle.
//   Push and pop in the same cycle are legal; count is unchanged.
//  B write to $0: accepted (handshake completes) and dropped.
//  Ordering: A is younger than every B entry.
//   A_act kills every queue entry with addr==a_addr (entry marked dead, pend bit cleared).
//   B_acc with b_addr==a_addr while A_act: accepted and dropped.
//   Dead entries still occupy a slot; they pop without asserting rf_we (1 cycle each).
//  b_ready = (count < DEPTH). It is registered-state based, with no combinational path from b_valid.
//  Full: b_ready=0, and B must hold b_valid/b_addr/b_data stable until accepted.
//  pend_mask: OR of one-hot(addr) over live entries, updated at the clock edge.
//   Case-3 direct writes never set a bit.
//  Starvation: counter increments each cycle a live head exists and A_act blocks it.
//   Counter clears on pop. a_stall = (counter >= STARVE_LIMIT).
//   The pipeline guarantees a_we=0 the cycle after a_stall=1.
//  Queue pointers wrap modulo DEPTH. count is width clog2(DEPTH+1).
// TESTING
//  T1 reset: assert reset=0 mid-queue (count=2).
//   -> b_ready=0, pend_mask=0, rf_we=0 immediately. After release, b_ready=1 and count=0.
//  T2 direct: A idle, queue empty, b_valid addr=5 data=0x1234.
//   -> same cycle rf_we=1 waddr=5 wdata=0x1234. pend_mask stays 0.
//  T3 conflict: A writes r3=0xAAAA each cycle while B sends r7=0x77.
//   -> rf_* = A. pend_mask[7]=1. When A idles, the next cycle writes r7=0x77 and pend_mask[7]=0.
//  T4 full: DEPTH=2, A busy, B sends r8 then r9.
//   -> b_ready=0 after 2 accepts. A third B (r10) stalls until the first pop.
//   -> Writes occur in order r8, r9, r10.
//  T5 kill: queue holds r4=0x1. A writes r4=0x2.
//   -> the entry dies and pend_mask[4]=0. The final r4 is 0x2; rf never sees 0x1.
//  T6 starve: A_act for 8 consecutive cycles with a live head.
//   -> a_stall=1 in cycle 9. The next cycle (a_we=0) drains the head, and a_stall returns to 0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (port A, highest priority, no backpressure) and multi-cycle units
// (port B, valid/ready). B writes that cannot go out immediately are parked in
// a small in-order queue that drains on cycles where A does not write.
// A per-register pending mask exposes the registers targeted by live queue
// entries so the hazard unit can stall their readers.
module rf_write_arbiter #(
   parameter int DEPTH        = 2,   // B-queue entries (1..4)
   parameter int STARVE_LIMIT = 8    // head wait cycles before a_stall
) (
   input  logic        clk,
   input  logic        reset,        // asynchronous, active-low
   input  logic        a_we,
   input  logic [4:0]  a_addr,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_addr,
   input  logic [31:0] b_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pend_mask,
   output logic        a_stall
);

   // Pointer width is at least one bit so DEPTH=1 still elaborates cleanly.
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   // Queue storage. Address/data slots carry no reset: a slot only matters
   // while its live bit is set, and live bits are cleared by reset.
   logic [4:0]        q_addr_reg [DEPTH];
   logic [31:0]       q_data_reg [DEPTH];
   logic [DEPTH-1:0]  q_live_reg;
   logic [DEPTH-1:0]  q_live_next;

   logic [PTR_W-1:0]  head_ptr_reg;
   logic [PTR_W-1:0]  head_ptr_next;
   logic [PTR_W-1:0]  tail_ptr_reg;
   logic [PTR_W-1:0]  tail_ptr_next;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic [STV_W-1:0]  starve_reg;
   logic [STV_W-1:0]  starve_next;

   // Per-cycle decode
   logic              a_act;
   logic              b_acc;
   logic              q_empty;
   logic              q_has_room;
   logic              head_live;
   logic [4:0]        head_addr;
   logic [31:0]       head_data;
   logic              sel_direct;
   logic              do_pop;
   logic              do_push;
   logic [DEPTH-1:0]  kill_vec;
   logic [31:0]       ent_mask [DEPTH];

   // Circular pointer advance; wraps modulo DEPTH even when DEPTH is not a
   // power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + 1'b1;
      end
      return r;
   endfunction

   // A write to $0 is a no-op, so it never occupies the port.
   assign a_act      = a_we && (a_addr != 5'd0);
   assign q_empty    = (count_reg == '0);
   assign q_has_room = (count_reg < CNT_W'(DEPTH));

   // Ready depends only on stored occupancy (never on b_valid); it is forced
   // low while reset is held so nothing is accepted into a queue being cleared.
   assign b_ready    = reset && q_has_room;
   assign b_acc      = b_valid && b_ready;

   assign head_addr  = q_addr_reg[head_ptr_reg];
   assign head_data  = q_data_reg[head_ptr_reg];
   assign head_live  = !q_empty && q_live_reg[head_ptr_reg];

   // Direct path: nothing queued and A idle, so B may use the port this cycle
   // without ever touching the queue or the pending mask.
   assign sel_direct = !a_act && q_empty && b_acc && (b_addr != 5'd0);

   // The head leaves whenever A leaves the port free. A dead head uses its
   // slot without writing, which keeps drain order strictly FIFO.
   assign do_pop     = !q_empty && !a_act;

   // B entries are older than A, so a B write to the same register A writes
   // in the same cycle would be overwritten anyway and is simply dropped.
   assign do_push    = b_acc && (b_addr != 5'd0) && !sel_direct &&
                       !(a_act && (b_addr == a_addr));

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         // An A write supersedes any older queued write to the same register.
         assign kill_vec[gi] = a_act && q_live_reg[gi] &&
                               (q_addr_reg[gi] == a_addr);
         // One-hot contribution of this entry to the pending mask.
         assign ent_mask[gi] = q_live_reg[gi] ? (32'd1 << q_addr_reg[gi]) : 32'd0;
      end
   endgenerate

   // Pending mask: OR of the targets of all live entries.
   always_comb begin
      pend_mask = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_mask = pend_mask | ent_mask[i];
      end
   end

   // Write-port select, first match wins: A, live head, direct B, idle.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (reset) begin
         if (a_act) begin
            rf_we    = 1'b1;
            rf_waddr = a_addr;
            rf_wdata = a_data;
         end else if (head_live) begin
            rf_we    = 1'b1;
            rf_waddr = head_addr;
            rf_wdata = head_data;
         end else if (sel_direct) begin
            rf_we    = 1'b1;
            rf_waddr = b_addr;
            rf_wdata = b_data;
         end
      end
   end

   // Next queue bookkeeping: kills, pop and push applied to the live bits,
   // pointers and occupancy.
   always_comb begin
      q_live_next   = q_live_reg & ~kill_vec;
      head_ptr_next = head_ptr_reg;
      tail_ptr_next = tail_ptr_reg;
      count_next    = count_reg;
      if (do_pop) begin
         q_live_next[head_ptr_reg] = 1'b0;
         head_ptr_next             = ptr_inc(head_ptr_reg);
      end
      if (do_push) begin
         q_live_next[tail_ptr_reg] = 1'b1;
         tail_ptr_next             = ptr_inc(tail_ptr_reg);
      end
      if (do_push && !do_pop) begin
         count_next = count_reg + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Starvation counter: counts cycles a live head is blocked by A, clears on
   // every pop, saturates at the limit.
   always_comb begin
      starve_next = starve_reg;
      if (do_pop) begin
         starve_next = '0;
      end else if (head_live && a_act && (starve_reg < STV_W'(STARVE_LIMIT))) begin
         starve_next = starve_reg + 1'b1;
      end
   end

   assign a_stall = (starve_reg >= STV_W'(STARVE_LIMIT));

   // Queue control state; reset discards every entry in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_live_reg   <= '0;
         head_ptr_reg <= '0;
         tail_ptr_reg <= '0;
         count_reg    <= '0;
         starve_reg   <= '0;
      end else begin
         q_live_reg   <= q_live_next;
         head_ptr_reg <= head_ptr_next;
         tail_ptr_reg <= tail_ptr_next;
         count_reg    <= count_next;
         starve_reg   <= starve_next;
      end
   end

   // Queue payload capture at the tail slot.
   always_ff @(posedge clk) begin
      if (do_push) begin
         q_addr_reg[tail_ptr_reg] <= b_addr;
         q_data_reg[tail_ptr_reg] <= b_data;
      end
   end

endmodule
